vga_controller_param: RTL and testbench

Parametrised VGA raster controller: the next-generation replacement for the fixed 640x480 controller. It generates H/V sync and BLANK with programmable porches and sync polarity. It issues pixel-fetch requests (coordinate plus linear address) a configurable number of cycles ahead of display, so host memories of any read latency line up with the beam. It also applies a per-channel enable and a frame-latched crosshair cursor of configurable thickness. It sits between the frame-buffer/automaton logic (host side) and the DAC pins (VGA side).

---
 rtl/vga_controller_param.sv | 246 ++++++++++++++++++++++++
 tb/tb_vga_controller_param.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_controller_param.sv
// vga_controller_param: parametrised VGA raster timing with look-ahead pixel fetch, channel enables and a frame-latched crosshair cursor.
// Latency: counter state -> oRequest +1 cycle; host data sampled at the FETCH_LAT+1 edge; pins (RGB/syncs/BLANK) +FETCH_LAT+1 cycles.
// Backpressure: none; the raster free-runs and the host must return data exactly FETCH_LAT-1 cycles after oRequest is seen.
// Ports: iCLK/iRST_N clock and async active-low reset; iCursor_* cursor controls (latched at h=0,v=0);
//        iRed/iGreen/iBlue host pixel data; oRequest/oCoord_*/oAddress/oFrame_Start fetch requests;
//        oVGA_* DAC pins (BLANK is active-high video valid, SYNC tied 0, CLOCK mirrors iCLK).
module vga_controller_param #(
  parameter int H_ACT     = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACT     = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit HS_POL    = 1'b0,
  parameter bit VS_POL    = 1'b0,
  parameter int FETCH_LAT = 2,
  parameter int CUR_HALF  = 1,
  parameter int COLOR_W   = 10,
  parameter int ADDR_W    = 20,
  parameter int CNT_W     = 11
) (
  input  logic               iCLK,
  input  logic               iRST_N,
  input  logic [3:0]         iCursor_RGB_EN,
  input  logic [CNT_W-1:0]   iCursor_X,
  input  logic [CNT_W-1:0]   iCursor_Y,
  input  logic [COLOR_W-1:0] iCursor_R,
  input  logic [COLOR_W-1:0] iCursor_G,
  input  logic [COLOR_W-1:0] iCursor_B,
  input  logic [COLOR_W-1:0] iRed,
  input  logic [COLOR_W-1:0] iGreen,
  input  logic [COLOR_W-1:0] iBlue,
  output logic               oRequest,
  output logic [CNT_W-1:0]   oCoord_X,
  output logic [CNT_W-1:0]   oCoord_Y,
  output logic [ADDR_W-1:0]  oAddress,
  output logic               oFrame_Start,
  output logic [COLOR_W-1:0] oVGA_R,
  output logic [COLOR_W-1:0] oVGA_G,
  output logic [COLOR_W-1:0] oVGA_B,
  output logic               oVGA_H_SYNC,
  output logic               oVGA_V_SYNC,
  output logic               oVGA_BLANK,
  output logic               oVGA_SYNC,
  output logic               oVGA_CLOCK
);

  localparam int H_TOT = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int V_TOT = V_SYNC + V_BP + V_ACT + V_FP;

  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOT - 1);
  localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOT - 1);
  localparam logic [CNT_W-1:0] XS      = CNT_W'(H_SYNC + H_BP);
  localparam logic [CNT_W-1:0] XE      = CNT_W'(H_SYNC + H_BP + H_ACT);
  localparam logic [CNT_W-1:0] YS      = CNT_W'(V_SYNC + V_BP);
  localparam logic [CNT_W-1:0] YE      = CNT_W'(V_SYNC + V_BP + V_ACT);
  localparam logic [CNT_W-1:0] HS_END  = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] VS_END  = CNT_W'(V_SYNC);
  localparam logic [CNT_W:0]   CUR_LIM = (CNT_W+1)'(CUR_HALF);

  // Raster counters and running address
  logic [CNT_W-1:0]  h_q, h_d, v_q, v_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  // Request stage
  logic              req_q, req_d;
  logic [CNT_W-1:0]  coord_x_q, coord_x_d, coord_y_q, coord_y_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic              frame_start_q, frame_start_d;

  // Decode delay line; the colour/sync output register is the final stage
  logic [FETCH_LAT-1:0] act_pipe_q, act_pipe_d;
  logic [FETCH_LAT-1:0] hs_pipe_q, hs_pipe_d;
  logic [FETCH_LAT-1:0] vs_pipe_q, vs_pipe_d;
  logic [CNT_W-1:0]     x_pipe_q [FETCH_LAT];
  logic [CNT_W-1:0]     x_pipe_d [FETCH_LAT];
  logic [CNT_W-1:0]     y_pipe_q [FETCH_LAT];
  logic [CNT_W-1:0]     y_pipe_d [FETCH_LAT];

  // Frame-latched cursor state
  logic [3:0]         cur_en_q, cur_en_d;
  logic [CNT_W-1:0]   cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic [COLOR_W-1:0] cur_r_q, cur_r_d, cur_g_q, cur_g_d, cur_b_q, cur_b_d;

  // Pin registers
  logic [COLOR_W-1:0] vga_r_q, vga_r_d, vga_g_q, vga_g_d, vga_b_q, vga_b_d;
  logic               hsync_q, hsync_d, vsync_q, vsync_d, blank_q, blank_d;

  // Combinational helpers
  logic               h_wrap, in_act, first_px, frame_latch;
  logic [ADDR_W-1:0]  fetch_addr;
  logic               act_o, hit;
  logic [CNT_W-1:0]   dx, dy;
  logic signed [CNT_W:0] diff_x, diff_y;
  logic [CNT_W:0]     abs_x, abs_y;

  // Counters, request stage, delay line input, cursor latch
  always_comb begin
    h_wrap      = (h_q == H_LAST);
    h_d         = h_wrap ? '0 : h_q + 1'b1;
    v_d         = v_q;
    if (h_wrap) begin
      v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
    end

    in_act      = (h_q >= XS) && (h_q < XE) && (v_q >= YS) && (v_q < YE);
    first_px    = (h_q == XS) && (v_q == YS);
    // The first pixel of a frame restarts the address run regardless of history
    fetch_addr  = first_px ? '0 : addr_q;
    addr_d      = in_act ? fetch_addr + 1'b1 : addr_q;

    req_d         = in_act;
    frame_start_d = in_act && first_px;
    coord_x_d     = in_act ? h_q - XS : coord_x_q;
    coord_y_d     = in_act ? v_q - YS : coord_y_q;
    address_d     = in_act ? fetch_addr : address_q;

    act_pipe_d[0] = in_act;
    hs_pipe_d[0]  = (h_q < HS_END);
    vs_pipe_d[0]  = (v_q < VS_END);
    x_pipe_d[0]   = h_q - XS;
    y_pipe_d[0]   = v_q - YS;
    for (int i = 1; i < FETCH_LAT; i++) begin
      act_pipe_d[i] = act_pipe_q[i-1];
      hs_pipe_d[i]  = hs_pipe_q[i-1];
      vs_pipe_d[i]  = vs_pipe_q[i-1];
      x_pipe_d[i]   = x_pipe_q[i-1];
      y_pipe_d[i]   = y_pipe_q[i-1];
    end

    // Sampled once per frame, well before any active pixel, so the picture never tears
    frame_latch = (h_q == '0) && (v_q == '0);
    cur_en_d    = frame_latch ? iCursor_RGB_EN : cur_en_q;
    cur_x_d     = frame_latch ? iCursor_X      : cur_x_q;
    cur_y_d     = frame_latch ? iCursor_Y      : cur_y_q;
    cur_r_d     = frame_latch ? iCursor_R      : cur_r_q;
    cur_g_d     = frame_latch ? iCursor_G      : cur_g_q;
    cur_b_d     = frame_latch ? iCursor_B      : cur_b_q;
  end

  // Pixel colour, cursor overlay and pin decodes
  always_comb begin
    act_o  = act_pipe_q[FETCH_LAT-1];
    dx     = x_pipe_q[FETCH_LAT-1];
    dy     = y_pipe_q[FETCH_LAT-1];
    // One extra bit keeps the distance signed so a cursor at 0 cannot wrap to the far edge
    diff_x = $signed({1'b0, dx}) - $signed({1'b0, cur_x_q});
    diff_y = $signed({1'b0, dy}) - $signed({1'b0, cur_y_q});
    abs_x  = diff_x[CNT_W] ? $unsigned(-diff_x) : $unsigned(diff_x);
    abs_y  = diff_y[CNT_W] ? $unsigned(-diff_y) : $unsigned(diff_y);
    hit    = cur_en_q[3] && ((abs_x <= CUR_LIM) || (abs_y <= CUR_LIM));

    vga_r_d = '0;
    vga_g_d = '0;
    vga_b_d = '0;
    if (act_o) begin
      vga_r_d = hit ? cur_r_q : iRed;
      vga_g_d = hit ? cur_g_q : iGreen;
      vga_b_d = hit ? cur_b_q : iBlue;
    end
    if (!cur_en_q[2]) vga_r_d = '0;
    if (!cur_en_q[1]) vga_g_d = '0;
    if (!cur_en_q[0]) vga_b_d = '0;

    hsync_d = hs_pipe_q[FETCH_LAT-1] ? HS_POL : ~HS_POL;
    vsync_d = vs_pipe_q[FETCH_LAT-1] ? VS_POL : ~VS_POL;
    blank_d = act_o;
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      h_q           <= '0;
      v_q           <= '0;
      addr_q        <= '0;
      req_q         <= 1'b0;
      coord_x_q     <= '0;
      coord_y_q     <= '0;
      address_q     <= '0;
      frame_start_q <= 1'b0;
      act_pipe_q    <= '0;
      hs_pipe_q     <= '0;
      vs_pipe_q     <= '0;
      for (int i = 0; i < FETCH_LAT; i++) begin
        x_pipe_q[i] <= '0;
        y_pipe_q[i] <= '0;
      end
      cur_en_q      <= '0;
      cur_x_q       <= '0;
      cur_y_q       <= '0;
      cur_r_q       <= '0;
      cur_g_q       <= '0;
      cur_b_q       <= '0;
      vga_r_q       <= '0;
      vga_g_q       <= '0;
      vga_b_q       <= '0;
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      blank_q       <= 1'b0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      addr_q        <= addr_d;
      req_q         <= req_d;
      coord_x_q     <= coord_x_d;
      coord_y_q     <= coord_y_d;
      address_q     <= address_d;
      frame_start_q <= frame_start_d;
      act_pipe_q    <= act_pipe_d;
      hs_pipe_q     <= hs_pipe_d;
      vs_pipe_q     <= vs_pipe_d;
      for (int i = 0; i < FETCH_LAT; i++) begin
        x_pipe_q[i] <= x_pipe_d[i];
        y_pipe_q[i] <= y_pipe_d[i];
      end
      cur_en_q      <= cur_en_d;
      cur_x_q       <= cur_x_d;
      cur_y_q       <= cur_y_d;
      cur_r_q       <= cur_r_d;
      cur_g_q       <= cur_g_d;
      cur_b_q       <= cur_b_d;
      vga_r_q       <= vga_r_d;
      vga_g_q       <= vga_g_d;
      vga_b_q       <= vga_b_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      blank_q       <= blank_d;
    end
  end

  assign oRequest     = req_q;
  assign oCoord_X     = coord_x_q;
  assign oCoord_Y     = coord_y_q;
  assign oAddress     = address_q;
  assign oFrame_Start = frame_start_q;
  assign oVGA_R       = vga_r_q;
  assign oVGA_G       = vga_g_q;
  assign oVGA_B       = vga_b_q;
  assign oVGA_H_SYNC  = hsync_q;
  assign oVGA_V_SYNC  = vsync_q;
  assign oVGA_BLANK   = blank_q;
  assign oVGA_SYNC    = 1'b0;
  assign oVGA_CLOCK   = iCLK;

endmodule

// File: tb/tb_vga_controller_param.sv
// tb_vga_controller_param: directed bench on a shrunken raster (15x8 cycles per frame) with two DUTs,
// FETCH_LAT=3 / active-low syncs and FETCH_LAT=1 / active-high syncs, each fed by a model memory.
// Every cycle is compared against an arithmetic raster model; directed points use hand-computed values.
module tb_vga_controller_param;
  localparam int CNT_W = 11, COLOR_W = 10, ADDR_W = 20;
  localparam int H_ACT = 8, H_FP = 2, H_SYNC = 3, H_BP = 2;
  localparam int V_ACT = 4, V_FP = 1, V_SYNC = 2, V_BP = 1;
  localparam int H_TOT = 15, V_TOT = 8, F_TOT = 120, XS = 5, YS = 3;
  localparam int FL0 = 3, FL1 = 1, CH = 1;

  logic iCLK = 1'b0;
  logic iRST_N = 1'b0;
  always #5 iCLK = ~iCLK;

  logic [3:0]         cur_en;
  logic [CNT_W-1:0]   cur_x, cur_y;
  logic [COLOR_W-1:0] cur_r, cur_g, cur_b;
  logic [COLOR_W-1:0] red0, green0, blue0, red1, green1, blue1;
  logic               req0, fs0, hs0, vs0, bl0, sync0, vclk0;
  logic               req1, fs1, hs1, vs1, bl1, sync1, vclk1;
  logic [CNT_W-1:0]   cx0, cy0, cx1, cy1;
  logic [ADDR_W-1:0]  addr0, addr1;
  logic [COLOR_W-1:0] r0, g0, b0, r1, g1, b1;

  vga_controller_param #(
    .H_ACT(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACT(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HS_POL(1'b0), .VS_POL(1'b0), .FETCH_LAT(FL0), .CUR_HALF(CH),
    .COLOR_W(COLOR_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)
  ) u_dut0 (
    .iCLK(iCLK), .iRST_N(iRST_N), .iCursor_RGB_EN(cur_en),
    .iCursor_X(cur_x), .iCursor_Y(cur_y),
    .iCursor_R(cur_r), .iCursor_G(cur_g), .iCursor_B(cur_b),
    .iRed(red0), .iGreen(green0), .iBlue(blue0),
    .oRequest(req0), .oCoord_X(cx0), .oCoord_Y(cy0), .oAddress(addr0),
    .oFrame_Start(fs0), .oVGA_R(r0), .oVGA_G(g0), .oVGA_B(b0),
    .oVGA_H_SYNC(hs0), .oVGA_V_SYNC(vs0), .oVGA_BLANK(bl0),
    .oVGA_SYNC(sync0), .oVGA_CLOCK(vclk0)
  );

  vga_controller_param #(
    .H_ACT(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACT(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HS_POL(1'b1), .VS_POL(1'b1), .FETCH_LAT(FL1), .CUR_HALF(CH),
    .COLOR_W(COLOR_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)
  ) u_dut1 (
    .iCLK(iCLK), .iRST_N(iRST_N), .iCursor_RGB_EN(cur_en),
    .iCursor_X(cur_x), .iCursor_Y(cur_y),
    .iCursor_R(cur_r), .iCursor_G(cur_g), .iCursor_B(cur_b),
    .iRed(red1), .iGreen(green1), .iBlue(blue1),
    .oRequest(req1), .oCoord_X(cx1), .oCoord_Y(cy1), .oAddress(addr1),
    .oFrame_Start(fs1), .oVGA_R(r1), .oVGA_G(g1), .oVGA_B(b1),
    .oVGA_H_SYNC(hs1), .oVGA_V_SYNC(vs1), .oVGA_BLANK(bl1),
    .oVGA_SYNC(sync1), .oVGA_CLOCK(vclk1)
  );

  int checks = 0, failures = 0;
  int k = 0;                       // rising edges since reset release
  logic e_req, e_fs;
  int e_x, e_y, e_addr;
  logic [3:0] m_en;
  int m_cx, m_cy, m_r, m_g, m_b;
  int hist [3];
  int mm_req, mm_pix0, mm_sync0, mm_pix1, mm_sync1;
  int st_hs0_low, st_vs0_low, st_bl0, st_fs, st_max_addr, st_hs1_high, st_vs1_high, st_bl1, st_g_nz;
  int last_fs, fs_period, first_req;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int iabs(input int a);
    return (a < 0) ? -a : a;
  endfunction

  // Expected pin values for counter state n (n<0 means still in the reset-cleared pipeline)
  function automatic void exp_pix(input int n, input bit hp, input bit vp,
                                  output int r, output int g, output int b,
                                  output bit hs, output bit vs, output bit bl);
    int h, v, x, y, a;
    bit act, hit;
    r = 0; g = 0; b = 0; hs = !hp; vs = !vp; bl = 0;
    if (n >= 0) begin
      h   = n % H_TOT;
      v   = (n / H_TOT) % V_TOT;
      act = (h >= XS) && (h < XS + H_ACT) && (v >= YS) && (v < YS + V_ACT);
      hs  = (h < H_SYNC) ? hp : !hp;
      vs  = (v < V_SYNC) ? vp : !vp;
      bl  = act;
      if (act) begin
        x   = h - XS;
        y   = v - YS;
        a   = y * H_ACT + x;
        hit = m_en[3] && (iabs(x - m_cx) <= CH || iabs(y - m_cy) <= CH);
        r   = hit ? m_r : (a & 1023);
        g   = hit ? m_g : ((a ^ 'h155) & 1023);
        b   = hit ? m_b : 'h2AA;
        if (!m_en[2]) r = 0;
        if (!m_en[1]) g = 0;
        if (!m_en[0]) b = 0;
      end
    end
  endfunction

  task automatic clear_stats();
    st_hs0_low = 0; st_vs0_low = 0; st_bl0 = 0; st_fs = 0; st_max_addr = 0;
    st_hs1_high = 0; st_vs1_high = 0; st_bl1 = 0;
  endtask

  task automatic model_reset();
    k = 0; e_req = 0; e_fs = 0; e_x = 0; e_y = 0; e_addr = 0;
    m_en = 4'b0; m_cx = 0; m_cy = 0; m_r = 0; m_g = 0; m_b = 0;
    for (int i = 0; i < 3; i++) hist[i] = 0;
    red0 = '0; green0 = '0; blue0 = '0; red1 = '0; green1 = '0; blue1 = '0;
  endtask

  // One clock: latch model cursor on (0,0), advance, compare everything, then feed the model memories
  task automatic step();
    int n, h, v, er, eg, eb;
    bit ehs, evs, ebl;
    if (k % F_TOT == 0) begin
      m_en = cur_en; m_cx = int'(cur_x); m_cy = int'(cur_y);
      m_r = int'(cur_r); m_g = int'(cur_g); m_b = int'(cur_b);
    end
    @(posedge iCLK);
    k++;
    @(negedge iCLK);
    n = k - 1;
    h = n % H_TOT;
    v = (n / H_TOT) % V_TOT;
    e_fs = 1'b0;
    e_req = 1'b0;
    if ((h >= XS) && (h < XS + H_ACT) && (v >= YS) && (v < YS + V_ACT)) begin
      e_req = 1'b1;
      e_x = h - XS; e_y = v - YS; e_addr = e_y * H_ACT + e_x;
      e_fs = (e_x == 0) && (e_y == 0);
    end
    if (req0 !== e_req || cx0 !== CNT_W'(e_x) || cy0 !== CNT_W'(e_y) ||
        addr0 !== ADDR_W'(e_addr) || fs0 !== e_fs) mm_req++;
    if (req1 !== e_req || cx1 !== CNT_W'(e_x) || cy1 !== CNT_W'(e_y) ||
        addr1 !== ADDR_W'(e_addr) || fs1 !== e_fs) mm_req++;
    exp_pix(k - FL0 - 1, 1'b0, 1'b0, er, eg, eb, ehs, evs, ebl);
    if (r0 !== COLOR_W'(er) || g0 !== COLOR_W'(eg) || b0 !== COLOR_W'(eb)) mm_pix0++;
    if (hs0 !== ehs || vs0 !== evs || bl0 !== ebl) mm_sync0++;
    exp_pix(k - FL1 - 1, 1'b1, 1'b1, er, eg, eb, ehs, evs, ebl);
    if (r1 !== COLOR_W'(er) || g1 !== COLOR_W'(eg) || b1 !== COLOR_W'(eb)) mm_pix1++;
    if (hs1 !== ehs || vs1 !== evs || bl1 !== ebl) mm_sync1++;
    if (hs0 == 1'b0) st_hs0_low++;
    if (vs0 == 1'b0) st_vs0_low++;
    if (bl0 == 1'b1) st_bl0++;
    if (hs1 == 1'b1) st_hs1_high++;
    if (vs1 == 1'b1) st_vs1_high++;
    if (bl1 == 1'b1) st_bl1++;
    if (g0 != '0 || b0 != '0) st_g_nz++;
    if (int'(addr0) > st_max_addr) st_max_addr = int'(addr0);
    if (fs0 == 1'b1) begin
      st_fs++;
      if (last_fs >= 0) fs_period = k - last_fs;
      last_fs = k;
    end
    hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = int'(addr0);
    red0   = COLOR_W'(hist[FL0-1]);
    green0 = COLOR_W'(hist[FL0-1] ^ 'h155);
    blue0  = 10'h2AA;
    red1   = addr1[COLOR_W-1:0];
    green1 = addr1[COLOR_W-1:0] ^ 10'h155;
    blue1  = 10'h2AA;
  endtask

  task automatic run_to(input int target);
    while (k < target) step();
  endtask

  task automatic reset_values(input string pfx);
    chk({pfx, "_req"},   64'(req0),  64'd0);
    chk({pfx, "_addr"},  64'(addr0), 64'd0);
    chk({pfx, "_cx"},    64'(cx0),   64'd0);
    chk({pfx, "_fs"},    64'(fs0),   64'd0);
    chk({pfx, "_r"},     64'(r0),    64'd0);
    chk({pfx, "_blank"}, 64'(bl0),   64'd0);
    chk({pfx, "_hs0"},   64'(hs0),   64'd1);
    chk({pfx, "_vs0"},   64'(vs0),   64'd1);
    chk({pfx, "_hs1"},   64'(hs1),   64'd0);
    chk({pfx, "_vs1"},   64'(vs1),   64'd0);
  endtask

  task automatic first_request(input string pfx);
    first_req = -1;
    while (k < 200 && first_req < 0) begin
      step();
      if (req0 === 1'b1) first_req = k;
    end
    chk({pfx, "_first_req_cycle"}, 64'(first_req), 64'd51);
    chk({pfx, "_first_coord"},     64'({cx0, cy0}), 64'd0);
    chk({pfx, "_first_addr"},      64'(addr0), 64'd0);
    chk({pfx, "_first_fs"},        64'(fs0),   64'd1);
  endtask

  task automatic pix(input string tag, input int at, input int er, input int eg, input int eb);
    run_to(at);
    chk({tag, "_r"}, 64'(r0), 64'(er));
    chk({tag, "_g"}, 64'(g0), 64'(eg));
    chk({tag, "_b"}, 64'(b0), 64'(eb));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    mm_req = 0; mm_pix0 = 0; mm_sync0 = 0; mm_pix1 = 0; mm_sync1 = 0;
    st_g_nz = 0; last_fs = -1; fs_period = 0;
    clear_stats();
    model_reset();
    cur_en = 4'b0111; cur_x = 11'd3; cur_y = 11'd1;
    cur_r = 10'd1023; cur_g = 10'd0; cur_b = 10'd5;

    // Power-up reset
    repeat (3) @(negedge iCLK);
    reset_values("por");
    chk("por_sync_pin", 64'(sync0), 64'd0);
    chk("clock_pin_low", 64'(vclk0), 64'd0);
    iRST_N = 1'b1;
    first_request("por");

    // Frame 1: sync/blank duty and address range
    run_to(120);
    clear_stats();
    run_to(240);
    chk("frame_hs0_low",   64'(st_hs0_low),  64'd24);
    chk("frame_vs0_low",   64'(st_vs0_low),  64'd30);
    chk("frame_blank0",    64'(st_bl0),      64'd32);
    chk("frame_hs1_high",  64'(st_hs1_high), 64'd24);
    chk("frame_vs1_high",  64'(st_vs1_high), 64'd30);
    chk("frame_blank1",    64'(st_bl1),      64'd32);
    chk("frame_fs_count",  64'(st_fs),       64'd1);
    chk("frame_fs_period", 64'(fs_period),   64'd120);
    chk("frame_last_addr", 64'(st_max_addr), 64'd31);
    chk("frame_req_model", 64'(mm_req),      64'd0);
    chk("frame_pix0_model", 64'(mm_pix0),    64'd0);

    // Frame 2: cursor at (0,0), full enables
    cur_en = 4'b1111; cur_x = 11'd0; cur_y = 11'd0;
    pix("cur_row_y1",  314, 1023, 0, 5);
    pix("cur_nowrap",  331, 23, 322, 682);
    pix("cur_col_x1",  340, 1023, 0, 5);
    cur_x = 11'd7; cur_y = 11'd3;
    pix("cur_move_hold", 343, 28, 329, 682);
    pix("cur_new_miss", 414, 0, 341, 682);
    pix("cur_new_hit",  463, 1023, 0, 5);

    // Frame 4: red channel only
    run_to(480);
    cur_en = 4'b0100;
    st_g_nz = 0;
    pix("red_only", 551, 10, 0, 0);

    // Asynchronous reset in the middle of an active line
    run_to(565);
    chk("pre_rst_blank", 64'(bl0),  64'd1);
    chk("pre_rst_req",   64'(req0), 64'd1);
    iRST_N = 1'b0;
    #1;
    reset_values("arst");
    repeat (3) @(posedge iCLK);
    @(negedge iCLK);
    model_reset();
    last_fs = -1;
    iRST_N = 1'b1;
    first_request("rerun");
    run_to(120);
    clear_stats();
    run_to(240);
    chk("rerun_blank0",    64'(st_bl0),   64'd32);
    chk("red_only_gb_zero", 64'(st_g_nz), 64'd0);
    chk("req_model",   64'(mm_req),   64'd0);
    chk("pix0_model",  64'(mm_pix0),  64'd0);
    chk("sync0_model", 64'(mm_sync0), 64'd0);
    chk("pix1_model",  64'(mm_pix1),  64'd0);
    chk("sync1_model", 64'(mm_sync1), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
